// File: rtl/demosaic_pkg.sv
// Shared types and constants for the demosaic back end: image geometry,
// luma weights, the pixel beat carried through the output buffer and the reader FSM.
package demosaic_pkg;
  localparam int IMG_W   = 128;
  localparam int IMG_H   = 128;
  localparam int ADDR_W  = 14;
  localparam int LUMA_KR = 77;
  localparam int LUMA_KG = 150;
  localparam int LUMA_KB = 29;

  typedef struct packed {
    logic [23:0] rgb;
    logic [7:0]  luma;
    logic        sof;
    logic        eol;
    logic        last;
  } px_beat_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} rd_state_e;

  // The weights sum to 256, so the worst case is 255*256 = 65280 and fits in 16 bits.
  function automatic logic [7:0] luma8(input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b);
    logic [15:0] acc;
    acc = 16'(LUMA_KR) * 16'(r) + 16'(LUMA_KG) * 16'(g) + 16'(LUMA_KB) * 16'(b);
    return acc[15:8];
  endfunction
endpackage

// File: rtl/rgb_stream_reader_if.sv
// Plane read port plus the RGB/luma output stream of the reader.
interface rgb_stream_reader_if;
  import demosaic_pkg::*;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        rdata_r, rdata_g, rdata_b;
  logic              out_valid, out_ready;
  logic [23:0]       out_rgb;
  logic [7:0]        out_luma;
  logic              out_sof, out_eol, out_last;

  modport master (output mem_addr, out_valid, out_rgb, out_luma, out_sof, out_eol, out_last,
                  input  rdata_r, rdata_g, rdata_b, out_ready);
  modport slave  (input  mem_addr, out_valid, out_rgb, out_luma, out_sof, out_eol, out_last,
                  output rdata_r, rdata_g, rdata_b, out_ready);
endinterface

// File: rtl/px_sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module px_sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_q, rd_q;
  logic [CW-1:0]               cnt_q;
  logic                        do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= (wr_q == PW'(DEPTH-1)) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) rd_q <= (rd_q == PW'(DEPTH-1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign dout  = mem_q[rd_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
endmodule

// File: rtl/rgb_stream_reader.sv
// Raster-scans the R/G/B planes after demosaic completes and streams one
// {RGB, luma} beat per handshake, with border masking and frame sideband.
module rgb_stream_reader
  import demosaic_pkg::*;
#(
  parameter int IMG_W       = demosaic_pkg::IMG_W,
  parameter int IMG_H       = demosaic_pkg::IMG_H,
  parameter int FIFO_DEPTH  = 2,
  parameter bit BORDER_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  rgb_stream_reader_if.master bus
);
  localparam int CBW = $clog2(IMG_W);
  localparam int CW  = $clog2(FIFO_DEPTH+1);
  localparam int OW  = CW + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W*IMG_H-1);

  rd_state_e         state_q;
  logic [ADDR_W-1:0] rd_ptr_q, mem_addr_q;
  logic              infl_q, infl_bdr_q, infl_sof_q, infl_eol_q, infl_last_q;
  logic              busy_q, done_q;

  logic [CBW-1:0]    col;
  logic [ADDR_W-1:0] row;
  logic              is_border, pop, issue;
  logic [OW-1:0]     occ_nxt;
  px_beat_t          wr_beat, head;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_cnt;

  assign col       = rd_ptr_q[CBW-1:0];
  assign row       = rd_ptr_q >> CBW;
  assign is_border = (row == '0) || (row == ADDR_W'(IMG_H-1)) ||
                     (col == '0) || (col == CBW'(IMG_W-1));

  assign pop = !fifo_empty && bus.out_ready;
  // Buffer slots plus the read in flight must never exceed the FIFO; a pop frees one now.
  assign occ_nxt = OW'(fifo_cnt) + OW'(infl_q) - OW'(pop);
  assign issue   = (state_q == ST_RUN) && (occ_nxt < OW'(FIFO_DEPTH)) && (!fifo_full || pop);

  always_comb begin
    wr_beat.rgb  = {bus.rdata_r, bus.rdata_g, bus.rdata_b};
    wr_beat.luma = luma8(bus.rdata_r, bus.rdata_g, bus.rdata_b);
    wr_beat.sof  = infl_sof_q;
    wr_beat.eol  = infl_eol_q;
    wr_beat.last = infl_last_q;
    if (BORDER_ZERO && infl_bdr_q) begin
      wr_beat.rgb  = '0;
      wr_beat.luma = '0;
    end
  end

  px_sync_fifo #(.WIDTH($bits(px_beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (infl_q),
    .din   (wr_beat),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= '0;
      mem_addr_q  <= '0;
      infl_q      <= 1'b0;
      infl_bdr_q  <= 1'b0;
      infl_sof_q  <= 1'b0;
      infl_eol_q  <= 1'b0;
      infl_last_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      infl_q <= issue;
      done_q <= 1'b0;
      if (issue) begin
        mem_addr_q  <= rd_ptr_q;
        infl_bdr_q  <= is_border;
        infl_sof_q  <= (rd_ptr_q == '0);
        infl_eol_q  <= (col == CBW'(IMG_W-1));
        infl_last_q <= (rd_ptr_q == LAST_ADDR);
      end
      case (state_q)
        ST_IDLE: if (start) begin
          rd_ptr_q <= '0;
          busy_q   <= 1'b1;
          state_q  <= ST_RUN;
        end
        ST_RUN: if (issue) begin
          if (rd_ptr_q == LAST_ADDR) state_q  <= ST_DRAIN;
          else                       rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        // Accepting the last-flagged beat empties the buffer, so done lands right after it.
        ST_DRAIN: if (pop && head.last) begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_rgb   = head.rgb;
  assign bus.out_luma  = head.luma;
  assign bus.out_sof   = head.sof;
  assign bus.out_eol   = head.eol;
  assign bus.out_last  = head.last;
endmodule

// File: tb/tb_rgb_stream_reader.sv
// Directed frame-level bench: two readers (border pass / border zero) on shared plane models.
module tb_rgb_stream_reader;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0;
  bit   mode_ff = 1'b0;
  logic [1:0] busy, done, vld;
  logic [34:0] beat [2];
  int total = 0, bad = 0, cyc = 0;

  always #5 clk = ~clk;

  rgb_stream_reader_if ifc0 ();
  rgb_stream_reader_if ifc1 ();

  assign ifc0.rdata_r   = mode_ff ? 8'hFF : ifc0.mem_addr[7:0];
  assign ifc0.rdata_g   = mode_ff ? 8'hFF : 8'h80;
  assign ifc0.rdata_b   = 8'hFF;
  assign ifc0.out_ready = out_ready;
  assign ifc1.rdata_r   = mode_ff ? 8'hFF : ifc1.mem_addr[7:0];
  assign ifc1.rdata_g   = mode_ff ? 8'hFF : 8'h80;
  assign ifc1.rdata_b   = 8'hFF;
  assign ifc1.out_ready = out_ready;

  rgb_stream_reader #(.BORDER_ZERO(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy[0]), .done(done[0]), .bus(ifc0));
  rgb_stream_reader #(.BORDER_ZERO(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy[1]), .done(done[1]), .bus(ifc1));

  assign vld     = {ifc1.out_valid, ifc0.out_valid};
  assign beat[0] = {ifc0.out_rgb, ifc0.out_luma, ifc0.out_sof, ifc0.out_eol, ifc0.out_last};
  assign beat[1] = {ifc1.out_rgb, ifc1.out_luma, ifc1.out_sof, ifc1.out_eol, ifc1.out_last};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [34:0] exp_beat(input int k, input bit bz, input bit ff);
    int r, g, b, y, col, row;
    bit bd;
    col = k % 128;
    row = k / 128;
    r = ff ? 255 : (k % 256);
    g = ff ? 255 : 128;
    b = 255;
    y = (77*r + 150*g + 29*b) / 256;
    bd = (row == 0) || (row == 127) || (col == 0) || (col == 127);
    if (bz && bd) begin r = 0; g = 0; b = 0; y = 0; end
    return {r[7:0], g[7:0], b[7:0], y[7:0], k == 0, col == 127, k == 16383};
  endfunction

  task automatic run_frame(input string nm, input bit ff, input int duty,
                           input int restart_at, input int abort_at);
    int acc[2], ndone[2];
    int start_cyc, first_cyc, last_cyc, maxlead, lead;
    logic [34:0] pbeat[2];
    bit pstall[2];
    bit seen, restarted, finished;
    logic [1:0] any_done;
    acc = '{0, 0}; ndone = '{0, 0}; pstall = '{0, 0}; pbeat = '{'0, '0};
    seen = 0; restarted = 0; finished = 0; maxlead = 0; first_cyc = 0; last_cyc = 0;
    mode_ff   = ff;
    out_ready = 1'b1;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    chk({nm, "_busy_rise"}, busy, 2'b11);
    for (int n = 0; n < 70000 && !finished; n++) begin
      start = (restart_at >= 0) && !restarted && (acc[0] == restart_at);
      if (start) restarted = 1;
      out_ready = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      if (abort_at >= 0 && acc[0] == abort_at) begin
        reset = 1'b1;
        tick();
        chk({nm, "_abort_state"}, {vld, busy}, 0);
        reset = 1'b0;
        start = 1'b0;
        any_done = '0;
        repeat (20) begin
          tick();
          any_done |= done;
        end
        chk({nm, "_abort_nodone"}, any_done, 0);
        chk({nm, "_abort_addr"}, ifc0.mem_addr, 0);
        finished = 1;
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (pstall[d]) chk($sformatf("%s_stable_d%0d", nm, d), beat[d], pbeat[d]);
          pstall[d] = vld[d] && !out_ready;
          pbeat[d]  = beat[d];
        end
        if (vld[0] && !seen) begin
          seen = 1;
          first_cyc = cyc;
          chk({nm, "_first_lat"}, cyc - start_cyc, 3);
        end
        if (seen && busy[0]) begin
          lead = int'(ifc0.mem_addr) + 1 - acc[0];
          if (lead > maxlead) maxlead = lead;
        end
        for (int d = 0; d < 2; d++) begin
          if (done[d]) begin
            ndone[d]++;
            chk($sformatf("%s_done_lat_d%0d", nm, d), cyc - last_cyc, 1);
          end
          if (vld[d] && out_ready) begin
            chk($sformatf("%s_beat%0d_d%0d", nm, acc[d], d), beat[d], exp_beat(acc[d], d[0], ff));
            // 77*129 + 150*128 + 29*255 = 36528, truncated >> 8 gives 142
            if (!ff && acc[d] == 129) chk($sformatf("%s_luma81_d%0d", nm, d), beat[d][10:3], 142);
            if (!ff && acc[d] == 129) chk($sformatf("%s_rgb81_d%0d", nm, d), beat[d][34:11], 24'h8180FF);
            if (ff && acc[d] == 129) chk($sformatf("%s_lumaff_d%0d", nm, d), beat[d][10:3], 255);
            if (d == 0) last_cyc = cyc;
            acc[d]++;
          end
        end
        if (ndone[0] > 0 && ndone[1] > 0) finished = 1;
        tick();
      end
    end
    if (!finished) chk({nm, "_timeout"}, 0, 1);
    else if (abort_at < 0) begin
      chk({nm, "_count_d0"}, acc[0], 16384);
      chk({nm, "_count_d1"}, acc[1], 16384);
      chk({nm, "_ndone"}, {ndone[1][7:0], ndone[0][7:0]}, 16'h0101);
      chk({nm, "_post_idle"}, {done, vld, busy}, 0);
      chk({nm, "_hold_addr"}, ifc0.mem_addr, 16383);
      if (duty >= 100) chk({nm, "_span"}, last_cyc - first_cyc, 16383);
    end
    chk({nm, "_lead_max"}, maxlead, 2);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_d0", {busy[0], done[0], vld[0], ifc0.mem_addr, beat[0]}, 0);
    chk("rst_d1", {busy[1], done[1], vld[1], ifc1.mem_addr, beat[1]}, 0);
    reset = 1'b0;
    tick();
    run_frame("A", 1'b0, 100, -1, -1);
    run_frame("B", 1'b1, 100, 500, -1);
    run_frame("C", 1'b0, 30, -1, 8000);
    run_frame("D", 1'b0, 100, -1, 300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
